// File: rtl/reg_port_seq.sv
// +----------------------------------------------------------------------------+
// | reg_port_seq                                                               |
// | Serialises operand fetches and writebacks onto a single-port register file.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module reg_port_seq #(
  parameter int SIZE   = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clkout,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [ADDR_W-1:0] op_src_a,
  input  logic [ADDR_W-1:0] op_src_b,
  input  logic              op_b_en,
  output logic              op_done,
  output logic [SIZE-1:0]   opa,
  output logic [SIZE-1:0]   opb,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [SIZE-1:0]   wb_data,
  output logic              rf_sal,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [SIZE-1:0]   rf_result,
  input  logic [SIZE-1:0]   rf_din
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD_A  = 3'd2,
    RD_B  = 3'd3,
    CAP_A = 3'd4,
    CAP_B = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic                rf_sal_q, rf_sal_d;
  logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
  logic [SIZE-1:0]     rf_result_q, rf_result_d;
  logic [SIZE-1:0]     opa_q, opa_d;
  logic [SIZE-1:0]     opb_q, opb_d;
  logic                op_done_q, op_done_d;
  logic                b_en_q, b_en_d;
  logic [ADDR_W-1:0]   src_b_q, src_b_d;

  // Writeback wins over a simultaneous op so earlier results are visible to it.
  assign wb_ready = (state_q == IDLE);
  assign op_ready = (state_q == IDLE) & ~wb_valid;

  always_comb begin
    state_d     = state_q;
    rf_sal_d    = rf_sal_q;
    rf_addr_d   = rf_addr_q;
    rf_result_d = rf_result_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    op_done_d   = 1'b0;
    b_en_d      = b_en_q;
    src_b_d     = src_b_q;
    case (state_q)
      IDLE: begin
        if (wb_valid) begin
          rf_sal_d    = 1'b1;
          rf_addr_d   = wb_addr;
          rf_result_d = wb_data;
          state_d     = WR;
        end else if (op_valid) begin
          rf_sal_d  = 1'b0;
          rf_addr_d = op_src_a;
          src_b_d   = op_src_b;
          b_en_d    = op_b_en;
          state_d   = RD_A;
        end
      end
      WR: begin
        rf_sal_d = 1'b0;
        state_d  = IDLE;
      end
      RD_A: begin
        if (b_en_q) begin
          rf_addr_d = src_b_q;
          state_d   = RD_B;
        end else begin
          state_d = CAP_A;
        end
      end
      RD_B: begin
        opa_d   = rf_din;
        state_d = CAP_B;
      end
      CAP_A: begin
        opa_d     = rf_din;
        opb_d     = '0;
        op_done_d = 1'b1;
        state_d   = IDLE;
      end
      CAP_B: begin
        opb_d     = rf_din;
        op_done_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkout or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rf_sal_q    <= 1'b0;
      rf_addr_q   <= '0;
      rf_result_q <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      op_done_q   <= 1'b0;
      b_en_q      <= 1'b0;
      src_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      rf_sal_q    <= rf_sal_d;
      rf_addr_q   <= rf_addr_d;
      rf_result_q <= rf_result_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      op_done_q   <= op_done_d;
      b_en_q      <= b_en_d;
      src_b_q     <= src_b_d;
    end
  end

  assign rf_sal    = rf_sal_q;
  assign rf_addr   = rf_addr_q;
  assign rf_result = rf_result_q;
  assign opa       = opa_q;
  assign opb       = opb_q;
  assign op_done   = op_done_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_port_seq.sv
// +----------------------------------------------------------------------------+
// | tb_reg_port_seq                                                            |
// | Self-checking bench: register-file model plus architectural register map.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_reg_port_seq;

  logic        clkout = 1'b0;
  logic        rst_n;
  logic        op_valid, op_ready, op_b_en, op_done;
  logic [4:0]  op_src_a, op_src_b;
  logic [31:0] opa, opb;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        rf_sal;
  logic [4:0]  rf_addr;
  logic [31:0] rf_result;
  logic [31:0] rf_din;

  logic [31:0] mem [32];      // physical register file seen by the DUT
  logic [31:0] arch [32];     // expected architectural contents
  int checks = 0;
  int errors = 0;

  reg_port_seq #(.SIZE(32), .ADDR_W(5)) dut (
    .clkout(clkout), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_src_a(op_src_a),
    .op_src_b(op_src_b), .op_b_en(op_b_en), .op_done(op_done),
    .opa(opa), .opb(opb),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_sal(rf_sal), .rf_addr(rf_addr), .rf_result(rf_result), .rf_din(rf_din)
  );

  always #5 clkout = ~clkout;

  always @(posedge clkout) begin
    if (rf_sal) mem[rf_addr] <= rf_result;
    rf_din <= mem[rf_addr];
  end

  // Issue a writeback and record it in the architectural map once accepted.
  task automatic do_wb(input logic [4:0] a, input logic [31:0] d);
    bit ok = 0;
    @(negedge clkout);
    wb_valid = 1'b1; wb_addr = a; wb_data = d;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (wb_ready) begin ok = 1; break; end
      @(negedge clkout);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL wb_accept_timeout got wb_ready=0 expected 1"); end
    @(posedge clkout); #1;
    wb_valid = 1'b0;
    arch[a] = d;
  endtask

  // Issue an op; lat = edges from accept (accept edge = 1) to op_done, 0 if none.
  task automatic do_op(input logic [4:0] a, input logic [4:0] b, input logic ben,
                       output int lat, output logic [31:0] ga, output logic [31:0] gb);
    bit ok = 0;
    lat = 0; ga = '0; gb = '0;
    @(negedge clkout);
    op_valid = 1'b1; op_src_a = a; op_src_b = b; op_b_en = ben;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (op_ready) begin ok = 1; break; end
      @(negedge clkout);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL op_accept_timeout got op_ready=0 expected 1"); end
    @(posedge clkout); #1;
    op_valid = 1'b0;
    op_src_a = $urandom; op_src_b = $urandom; op_b_en = $urandom;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clkout);
      if (op_done) begin lat = k; ga = opa; gb = opb; break; end
      @(posedge clkout);
    end
  endtask

  task automatic test_reset;
    checks++; if (rf_sal !== 1'b0)  begin errors++; $display("FAIL reset_rf_sal got %b expected 0", rf_sal); end
    checks++; if (rf_addr !== 5'd0) begin errors++; $display("FAIL reset_rf_addr got %h expected 0", rf_addr); end
    checks++; if (rf_result !== 32'd0) begin errors++; $display("FAIL reset_rf_result got %h expected 0", rf_result); end
    checks++; if (opa !== 32'd0 || opb !== 32'd0) begin errors++; $display("FAIL reset_operands got %h/%h expected 0/0", opa, opb); end
    checks++; if (op_done !== 1'b0) begin errors++; $display("FAIL reset_op_done got %b expected 0", op_done); end
    checks++; if (op_ready !== 1'b1 || wb_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b%b expected 11", op_ready, wb_ready); end
  endtask

  task automatic test_write;
    @(negedge clkout);
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEADBEEF;
    @(posedge clkout); #1;
    wb_valid = 1'b0;
    arch[3] = 32'hDEADBEEF;
    checks++; if (rf_sal !== 1'b1 || rf_addr !== 5'd3) begin errors++; $display("FAIL wr_issue got sal=%b addr=%h expected 1/03", rf_sal, rf_addr); end
    checks++; if (rf_result !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_data got %h expected deadbeef", rf_result); end
    checks++; if (wb_ready !== 1'b0 || op_ready !== 1'b0) begin errors++; $display("FAIL wr_busy got %b%b expected 00", wb_ready, op_ready); end
    @(posedge clkout); #1;
    checks++; if (rf_sal !== 1'b0) begin errors++; $display("FAIL wr_release got %b expected 0", rf_sal); end
    checks++; if (mem[3] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_commit got %h expected deadbeef", mem[3]); end
    checks++; if (rf_result !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_result_hold got %h expected deadbeef", rf_result); end
    do_wb(5'd7, 32'h12345678);
  endtask

  task automatic test_two_src;
    int lat; logic [31:0] ga, gb;
    do_op(5'd3, 5'd7, 1'b1, lat, ga, gb);
    checks++; if (lat !== 4) begin errors++; $display("FAIL two_src_latency got %0d expected 4", lat); end
    checks++; if (ga !== 32'hDEADBEEF) begin errors++; $display("FAIL two_src_opa got %h expected deadbeef", ga); end
    checks++; if (gb !== 32'h12345678) begin errors++; $display("FAIL two_src_opb got %h expected 12345678", gb); end
    @(negedge clkout);
    checks++; if (op_done !== 1'b0) begin errors++; $display("FAIL op_done_pulse got %b expected 0", op_done); end
    checks++; if (opa !== 32'hDEADBEEF) begin errors++; $display("FAIL opa_hold got %h expected deadbeef", opa); end
  endtask

  task automatic test_one_src;
    int lat; logic [31:0] ga, gb;
    do_op(5'd7, 5'd3, 1'b0, lat, ga, gb);
    checks++; if (lat !== 3) begin errors++; $display("FAIL one_src_latency got %0d expected 3", lat); end
    checks++; if (ga !== 32'h12345678) begin errors++; $display("FAIL one_src_opa got %h expected 12345678", ga); end
    checks++; if (gb !== 32'd0) begin errors++; $display("FAIL one_src_opb got %h expected 0", gb); end
  endtask

  task automatic test_priority;
    int lat; logic [31:0] ga, gb;
    @(negedge clkout);
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hA5A5A5A5;
    op_valid = 1'b1; op_src_a = 5'd5; op_src_b = 5'd0; op_b_en = 1'b0;
    #1;
    checks++; if (op_ready !== 1'b0 || wb_ready !== 1'b1) begin errors++; $display("FAIL prio_ready got op=%b wb=%b expected 0/1", op_ready, wb_ready); end
    @(posedge clkout); #1;
    wb_valid = 1'b0;
    arch[5] = 32'hA5A5A5A5;
    checks++; if (rf_sal !== 1'b1 || rf_addr !== 5'd5) begin errors++; $display("FAIL prio_wb_first got sal=%b addr=%h expected 1/05", rf_sal, rf_addr); end
    do_op(5'd5, 5'd0, 1'b0, lat, ga, gb);
    checks++; if (lat !== 3 || ga !== arch[5]) begin errors++; $display("FAIL prio_read_after_write got lat=%0d opa=%h expected 3/%h", lat, ga, arch[5]); end
  endtask

  task automatic test_wb_stall;
    logic [31:0] old_a, old_b;
    int lat = 0;
    old_a = arch[3]; old_b = arch[7];
    @(negedge clkout);
    op_valid = 1'b1; op_src_a = 5'd3; op_src_b = 5'd7; op_b_en = 1'b1;
    @(posedge clkout); #1;
    op_valid = 1'b0;
    @(posedge clkout); #1;
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'hCAFEF00D;
    for (int k = 2; k <= 12; k++) begin
      @(negedge clkout);
      if (op_done) begin lat = k; break; end
      checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL stall_wb_ready got %b expected 0 at edge %0d", wb_ready, k); end
      @(posedge clkout);
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL stall_latency got %0d expected 4", lat); end
    checks++; if (opa !== old_a || opb !== old_b) begin errors++; $display("FAIL stall_operands got %h/%h expected %h/%h", opa, opb, old_a, old_b); end
    checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL stall_release got %b expected 1", wb_ready); end
    @(posedge clkout); #1;
    wb_valid = 1'b0;
    arch[7] = 32'hCAFEF00D;
    @(posedge clkout); #1;
    checks++; if (mem[7] !== arch[7]) begin errors++; $display("FAIL stall_commit got %h expected %h", mem[7], arch[7]); end
    checks++; if (opa !== old_a || opb !== old_b) begin errors++; $display("FAIL stall_no_corrupt got %h/%h expected %h/%h", opa, opb, old_a, old_b); end
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] ga, gb;
    bit seen;
    @(negedge clkout);
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h1;
    @(posedge clkout); #1;
    wb_valid = 1'b0;
    checks++; if (rf_sal !== 1'b1) begin errors++; $display("FAIL rst_pre_wr got %b expected 1", rf_sal); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rf_sal !== 1'b0) begin errors++; $display("FAIL rst_async_sal got %b expected 0", rf_sal); end
    checks++; if (rf_addr !== 5'd0 || rf_result !== 32'd0 || opa !== 32'd0 || opb !== 32'd0 || op_done !== 1'b0)
      begin errors++; $display("FAIL rst_outputs got addr=%h res=%h opa=%h opb=%h done=%b expected all 0", rf_addr, rf_result, opa, opb, op_done); end
    @(posedge clkout); #1;
    checks++; if (mem[9] !== arch[9]) begin errors++; $display("FAIL rst_write_dropped got %h expected %h", mem[9], arch[9]); end
    @(negedge clkout); rst_n = 1'b1;
    // An op interrupted by reset must never complete.
    @(negedge clkout);
    op_valid = 1'b1; op_src_a = 5'd3; op_src_b = 5'd9; op_b_en = 1'b1;
    @(posedge clkout); #1;
    op_valid = 1'b0;
    @(posedge clkout); #1;
    rst_n = 1'b0;
    @(negedge clkout); rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clkout);
      if (op_done) seen = 1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_no_op_done got %b expected 0", seen); end
    do_op(5'd9, 5'd3, 1'b1, lat, ga, gb);
    checks++; if (lat !== 4 || ga !== arch[9] || gb !== arch[3])
      begin errors++; $display("FAIL rst_recover got lat=%0d %h/%h expected 4/%h/%h", lat, ga, gb, arch[9], arch[3]); end
  endtask

  task automatic test_random;
    int lat; logic [31:0] ga, gb, ea, eb;
    logic [4:0] a, b; logic ben;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_wb(5'($urandom), $urandom);
      end else begin
        a = 5'($urandom); b = ($urandom_range(0, 3) == 0) ? a : 5'($urandom); ben = 1'($urandom);
        ea = arch[a]; eb = ben ? arch[b] : 32'd0;
        do_op(a, b, ben, lat, ga, gb);
        checks++;
        if (lat !== (ben ? 4 : 3) || ga !== ea || gb !== eb)
          begin errors++; $display("FAIL random_op a=%0d b=%0d ben=%b got lat=%0d %h/%h expected %0d/%h/%h", a, b, ben, lat, ga, gb, ben ? 4 : 3, ea, eb); end
      end
      if ($urandom_range(0, 3) == 0) @(posedge clkout);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    op_valid = 1'b0; op_src_a = '0; op_src_b = '0; op_b_en = 1'b0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    for (int i = 0; i < 32; i++) begin
      mem[i]  = $urandom;
      arch[i] = mem[i];
    end
    repeat (3) @(posedge clkout);
    #1;
    test_reset;
    @(negedge clkout); rst_n = 1'b1;
    test_write;
    test_two_src;
    test_one_src;
    test_priority;
    test_wb_stall;
    test_reset_mid;
    test_random;
    repeat (2) @(posedge clkout);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
